// File: rtl/l1_l2_pkg.sv
// Shared types and widths for the L1I/L1D to L2 port arbiter.
package l1_l2_pkg;

  localparam int ADDR_W = 26;
  localparam int LINE_W = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWN_L1I = 1'b0;
  localparam logic OWN_L1D = 1'b1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the side not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       owner
);

  always_comb begin
    owner = req[1];
    if (req == 2'b11) owner = ~last_grant;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = (|req) && (owner == gi[0]);
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 port between L1I and L1D; one outstanding line
// transaction at a time, all outputs registered.
module l1_l2_arbiter
  import l1_l2_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_L1I_L2,
  input  logic [ADDR_W-1:0] addr_L1I_L2,
  output logic              ready_L2_L1I,
  output logic [LINE_W-1:0] read_data_L2_L1I,
  input  logic              read_L1D_L2,
  input  logic              write_L1D_L2,
  input  logic [ADDR_W-1:0] addr_L1D_L2,
  input  logic [LINE_W-1:0] write_data_L1D_L2,
  output logic              ready_L2_L1D,
  output logic [LINE_W-1:0] read_data_L2_L1D,
  output logic              read_C_L2,
  output logic              write_C_L2,
  output logic [ADDR_W-1:0] addr_C_L2,
  output logic [LINE_W-1:0] write_data_C_L2,
  input  logic              ready_L2,
  input  logic [LINE_W-1:0] read_data_L2,
  output logic              busy
);

  state_t            state;
  logic              last_grant;
  logic              own_reg;
  logic [LINE_W-1:0] line_buf;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              owner;
  op_t               grant_op;

  assign req = {read_L1D_L2 | write_L1D_L2, read_L1I_L2};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .owner      (owner)
  );

  // A dirty line must reach L2 before its refill, so write beats read on L1D.
  assign grant_op = (owner == OWN_L1D && write_L1D_L2) ? OP_WR : OP_RD;

  assign read_data_L2_L1I = line_buf;
  assign read_data_L2_L1D = line_buf;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      last_grant      <= OWN_L1D;
      own_reg         <= OWN_L1I;
      read_C_L2       <= 1'b0;
      write_C_L2      <= 1'b0;
      addr_C_L2       <= '0;
      write_data_C_L2 <= '0;
      line_buf        <= '0;
      ready_L2_L1I    <= 1'b0;
      ready_L2_L1D    <= 1'b0;
      busy            <= 1'b0;
    end else begin
      ready_L2_L1I <= 1'b0;
      ready_L2_L1D <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            own_reg         <= owner;
            state           <= ISSUE;
            busy            <= 1'b1;
            read_C_L2       <= (grant_op == OP_RD);
            write_C_L2      <= (grant_op == OP_WR);
            addr_C_L2       <= (owner == OWN_L1I) ? addr_L1I_L2 : addr_L1D_L2;
            write_data_C_L2 <= (grant_op == OP_WR) ? write_data_L1D_L2 : '0;
          end
        end
        ISSUE: begin
          if (ready_L2) begin
            line_buf   <= read_data_L2;
            last_grant <= own_reg;
            read_C_L2  <= 1'b0;
            write_C_L2 <= 1'b0;
            state      <= RESP;
            if (own_reg == OWN_L1I) ready_L2_L1I <= 1'b1;
            else                    ready_L2_L1D <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          read_C_L2  <= 1'b0;
          write_C_L2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: vector table, corner sequences, random traffic.
module tb_l1_l2_arbiter;
  import l1_l2_pkg::*;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              read_L1I_L2 = 1'b0;
  logic [ADDR_W-1:0] addr_L1I_L2 = '0;
  logic              ready_L2_L1I;
  logic [LINE_W-1:0] read_data_L2_L1I;
  logic              read_L1D_L2 = 1'b0;
  logic              write_L1D_L2 = 1'b0;
  logic [ADDR_W-1:0] addr_L1D_L2 = '0;
  logic [LINE_W-1:0] write_data_L1D_L2 = '0;
  logic              ready_L2_L1D;
  logic [LINE_W-1:0] read_data_L2_L1D;
  logic              read_C_L2;
  logic              write_C_L2;
  logic [ADDR_W-1:0] addr_C_L2;
  logic [LINE_W-1:0] write_data_C_L2;
  logic              ready_L2 = 1'b0;
  logic [LINE_W-1:0] read_data_L2 = '0;
  logic              busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic model_last = 1'b1;  // side served most recently; L1D after reset

  typedef struct {
    bit   ri;
    bit   rd;
    bit   wr;
    int   lat;
    logic eown;
    logic ewr;
  } vec_t;
  vec_t tbl [8];

  l1_l2_arbiter dut (
    .clk               (clk),
    .nrst              (nrst),
    .read_L1I_L2       (read_L1I_L2),
    .addr_L1I_L2       (addr_L1I_L2),
    .ready_L2_L1I      (ready_L2_L1I),
    .read_data_L2_L1I  (read_data_L2_L1I),
    .read_L1D_L2       (read_L1D_L2),
    .write_L1D_L2      (write_L1D_L2),
    .addr_L1D_L2       (addr_L1D_L2),
    .write_data_L1D_L2 (write_data_L1D_L2),
    .ready_L2_L1D      (ready_L2_L1D),
    .read_data_L2_L1D  (read_data_L2_L1D),
    .read_C_L2         (read_C_L2),
    .write_C_L2        (write_C_L2),
    .addr_C_L2         (addr_C_L2),
    .write_data_C_L2   (write_data_C_L2),
    .ready_L2          (ready_L2),
    .read_data_L2      (read_data_L2),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {16{$urandom}};
  endfunction

  // One complete transaction, entered and left at a negedge while the DUT is idle.
  task automatic do_txn(input logic exp_own, input logic exp_wr, input int lat,
                        input logic [LINE_W-1:0] rdata, input bit scramble);
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ew;
    ea = exp_own ? addr_L1D_L2 : addr_L1I_L2;
    ew = write_data_L1D_L2;
    @(posedge clk); @(negedge clk);
    chk("issue_busy", LINE_W'(busy), LINE_W'(1'b1));
    chk("issue_op", LINE_W'({read_C_L2, write_C_L2}), LINE_W'({!exp_wr, exp_wr}));
    chk("issue_addr", LINE_W'(addr_C_L2), LINE_W'(ea));
    if (exp_wr) chk("issue_wdata", write_data_C_L2, ew);
    for (int c = 0; c < lat; c++) begin
      if (scramble) begin
        addr_L1I_L2 = ADDR_W'($urandom);
        addr_L1D_L2 = ADDR_W'($urandom);
      end
      @(posedge clk); @(negedge clk);
      chk("hold_op", LINE_W'({read_C_L2, write_C_L2}), LINE_W'({!exp_wr, exp_wr}));
      chk("hold_addr", LINE_W'(addr_C_L2), LINE_W'(ea));
      chk("hold_no_ready", LINE_W'({ready_L2_L1I, ready_L2_L1D}), '0);
    end
    ready_L2 = 1'b1;
    read_data_L2 = rdata;
    @(posedge clk); @(negedge clk);
    ready_L2 = 1'b0;
    read_data_L2 = rnd_line();
    chk("resp_ready", LINE_W'({ready_L2_L1I, ready_L2_L1D}), LINE_W'(exp_own ? 2'b01 : 2'b10));
    if (!exp_wr) chk("resp_data", exp_own ? read_data_L2_L1D : read_data_L2_L1I, rdata);
    chk("resp_req_low", LINE_W'({read_C_L2, write_C_L2}), '0);
    @(posedge clk); @(negedge clk);
    chk("idle_busy", LINE_W'(busy), '0);
    chk("idle_ready", LINE_W'({ready_L2_L1I, ready_L2_L1D}), '0);
    if (!exp_own)    read_L1I_L2  = 1'b0;
    else if (exp_wr) write_L1D_L2 = 1'b0;
    else             read_L1D_L2  = 1'b0;
    model_last = exp_own;
  endtask

  task automatic raise_i();
    read_L1I_L2 = 1'b1;
    addr_L1I_L2 = ADDR_W'($urandom);
  endtask

  task automatic raise_d(input bit rd, input bit wr);
    read_L1D_L2       = rd;
    write_L1D_L2      = wr;
    addr_L1D_L2       = ADDR_W'($urandom);
    write_data_L1D_L2 = rnd_line();
  endtask

  initial begin
    logic pi, pd, own, wr;

    tbl[0] = '{1, 1, 0, 0, 1'b0, 1'b0};
    tbl[1] = '{1, 0, 0, 1, 1'b1, 1'b0};
    tbl[2] = '{0, 1, 0, 2, 1'b0, 1'b0};
    tbl[3] = '{1, 0, 0, 0, 1'b1, 1'b0};
    tbl[4] = '{0, 1, 1, 1, 1'b0, 1'b0};
    tbl[5] = '{0, 0, 0, 0, 1'b1, 1'b1};
    tbl[6] = '{0, 0, 0, 3, 1'b1, 1'b0};
    tbl[7] = '{0, 0, 1, 0, 1'b1, 1'b1};

    #2 nrst = 1'b0;
    @(negedge clk);
    chk("rst_busy", LINE_W'(busy), '0);
    chk("rst_ctl", LINE_W'({read_C_L2, write_C_L2, ready_L2_L1I, ready_L2_L1D}), '0);
    chk("rst_addr", LINE_W'(addr_C_L2), '0);
    chk("rst_data", read_data_L2_L1I | read_data_L2_L1D | write_data_C_L2, '0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ri) raise_i();
      if (tbl[i].rd || tbl[i].wr) raise_d(tbl[i].rd, tbl[i].wr);
      do_txn(tbl[i].eown, tbl[i].ewr, tbl[i].lat, rnd_line(), 1'b0);
    end

    // Lone L1I read, L2 answers in the first ISSUE cycle.
    read_L1I_L2 = 1'b1;
    addr_L1I_L2 = 26'h0000040;
    do_txn(1'b0, 1'b0, 0, {64{8'hA5}}, 1'b0);

    // Write-back then refill from the same L1D request pair.
    raise_d(1'b1, 1'b1);
    addr_L1D_L2 = 26'h1234567;
    do_txn(1'b1, 1'b1, 1, rnd_line(), 1'b0);
    do_txn(1'b1, 1'b0, 0, rnd_line(), 1'b0);

    // Long L2 wait with requester address churning underneath.
    raise_i();
    do_txn(1'b0, 1'b0, 10, rnd_line(), 1'b1);

    // Spurious L2 ready while idle.
    ready_L2 = 1'b1;
    read_data_L2 = rnd_line();
    @(posedge clk); @(negedge clk);
    ready_L2 = 1'b0;
    chk("spur_ready", LINE_W'({ready_L2_L1I, ready_L2_L1D}), '0);
    chk("spur_busy", LINE_W'(busy), '0);
    @(posedge clk); @(negedge clk);
    chk("spur_ready2", LINE_W'({ready_L2_L1I, ready_L2_L1D, busy}), '0);

    // Reset in the middle of ISSUE; the L1D read is then granted afresh.
    raise_d(1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("abort_issue", LINE_W'(read_C_L2), LINE_W'(1'b1));
    #2 nrst = 1'b0;
    #1;
    chk("abort_ctl", LINE_W'({read_C_L2, write_C_L2, ready_L2_L1I, ready_L2_L1D, busy}), '0);
    chk("abort_addr", LINE_W'(addr_C_L2), '0);
    chk("abort_data", read_data_L2_L1I | read_data_L2_L1D | write_data_C_L2, '0);
    @(negedge clk);
    nrst = 1'b1;
    model_last = 1'b1;
    do_txn(1'b1, 1'b0, 2, rnd_line(), 1'b0);

    // Random traffic against the transaction-level arbitration model.
    for (int it = 0; it < 80; it++) begin
      if (!read_L1I_L2 && ($urandom_range(0, 1) == 1)) raise_i();
      if (!read_L1D_L2 && !write_L1D_L2) begin
        case ($urandom_range(0, 3))
          1: raise_d(1'b1, 1'b0);
          2: raise_d(1'b0, 1'b1);
          3: raise_d(1'b1, 1'b1);
          default: ;
        endcase
      end
      pi = read_L1I_L2;
      pd = read_L1D_L2 | write_L1D_L2;
      if (!pi && !pd) begin
        ready_L2 = ($urandom_range(0, 1) == 1);
        @(posedge clk); @(negedge clk);
        ready_L2 = 1'b0;
        chk("rnd_idle", LINE_W'({busy, read_C_L2, write_C_L2, ready_L2_L1I, ready_L2_L1D}), '0);
      end else begin
        own = (pi && pd) ? !model_last : pd;
        wr  = own && write_L1D_L2;
        do_txn(own, wr, int'($urandom_range(0, 4)), rnd_line(), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
